// File: rtl/parity_pkg.sv
// parity_pkg: shared state encoding and parity-sense constants for the parity frame path
package parity_pkg;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam int PAR_EVEN = 0;
    localparam int PAR_ODD  = 1;
    typedef enum logic [1:0] {
        ST_IDLE   = S_IDLE,
        ST_SHIFT  = S_SHIFT,
        ST_PARITY = S_PARITY
    } state_t;
endpackage

// File: rtl/parity_acc.sv
// parity_acc: 1-bit serial XOR accumulator with synchronous clear
module parity_acc (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    q <= 1'b0;
        else if (clr) q <= 1'b0;
        else if (en)  q <= q ^ d;
    end
endmodule

// File: rtl/parity_frame_ctrl.sv
// parity_frame_ctrl: serialises parallel words LSB-first with a trailing parity bit
module parity_frame_ctrl
    import parity_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ODD_PAR = PAR_EVEN,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_out,
    output logic              ser_first,
    output logic              ser_last,
    output logic              busy,
    output logic              par_bit,
    output logic [CNT_W-1:0]  frame_cnt
);
    localparam int BW = $clog2(DATA_W);
    localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);
    localparam logic ODD = (ODD_PAR == PAR_ODD);

    state_t            state, state_nx;
    logic [DATA_W-1:0] shreg;
    logic [BW-1:0]     bit_cnt;
    logic              acc, accept, shift_hs, par_hs;

    assign accept   = in_valid & in_ready;
    assign shift_hs = (state == ST_SHIFT) & ser_ready;
    assign par_hs   = (state == ST_PARITY) & ser_ready;

    parity_acc u_acc (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  (shift_hs),
        .d   (shreg[0]),
        .q   (acc)
    );

    // Serial outputs depend only on registered state; in_ready alone sees ser_ready for back-to-back
    always_comb begin
        state_nx  = state;
        in_ready  = rst & ((state == ST_IDLE) | par_hs);
        ser_valid = state != ST_IDLE;
        busy      = state != ST_IDLE;
        ser_first = (state == ST_SHIFT) & (bit_cnt == '0);
        ser_last  = state == ST_PARITY;
        ser_out   = (state == ST_SHIFT) ? shreg[0] : (state == ST_PARITY) ? (acc ^ ODD) : 1'b0;
        case (state)
            ST_IDLE:   state_nx = accept ? ST_SHIFT : ST_IDLE;
            ST_SHIFT:  state_nx = (ser_ready && bit_cnt == LAST) ? ST_PARITY : ST_SHIFT;
            ST_PARITY: state_nx = ser_ready ? (accept ? ST_SHIFT : ST_IDLE) : ST_PARITY;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            par_bit   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                shreg   <= in_data;
                bit_cnt <= '0;
            end else if (shift_hs) begin
                shreg   <= shreg >> 1;
                bit_cnt <= bit_cnt + BW'(1);
            end
            if (par_hs) begin
                par_bit   <= ser_out;
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_parity_frame_ctrl.sv
// tb_parity_frame_ctrl: directed checks of even and odd parity framers driven in lockstep
module tb_parity_frame_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       ser_ready = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       sel = 1'b0;
    logic       rdy_e, val_e, out_e, fst_e, lst_e, bsy_e, par_e;
    logic       rdy_o, val_o, out_o, fst_o, lst_o, bsy_o, par_o;
    logic [7:0] cnt_e, cnt_o;
    logic       so, sv, sf, sl, sb, sp;
    logic [7:0] sc;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    parity_frame_ctrl #(.DATA_W(8), .ODD_PAR(0), .CNT_W(8)) dut_e (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_e), .in_data(in_data),
        .ser_valid(val_e), .ser_ready(ser_ready), .ser_out(out_e), .ser_first(fst_e),
        .ser_last(lst_e), .busy(bsy_e), .par_bit(par_e), .frame_cnt(cnt_e)
    );

    parity_frame_ctrl #(.DATA_W(8), .ODD_PAR(1), .CNT_W(8)) dut_o (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_o), .in_data(in_data),
        .ser_valid(val_o), .ser_ready(ser_ready), .ser_out(out_o), .ser_first(fst_o),
        .ser_last(lst_o), .busy(bsy_o), .par_bit(par_o), .frame_cnt(cnt_o)
    );

    always_comb begin
        so = sel ? out_o : out_e;
        sv = sel ? val_o : val_e;
        sf = sel ? fst_o : fst_e;
        sl = sel ? lst_o : lst_e;
        sb = sel ? bsy_o : bsy_e;
        sp = sel ? par_o : par_e;
        sc = sel ? cnt_o : cnt_e;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_bit(input string tag, input logic eb, input logic ef, input logic el);
        chk({tag, "_valid"}, 32'(sv), 1);
        chk({tag, "_out"}, 32'(so), 32'(eb));
        chk({tag, "_first"}, 32'(sf), 32'(ef));
        chk({tag, "_last"}, 32'(sl), 32'(el));
    endtask

    // Called just after a negedge with the DUT idle; returns at the negedge after the trailer
    task automatic run_frame(input logic [7:0] w, input logic odd, input logic stall,
                             input logic exp_par, input logic [7:0] exp_cnt);
        sel = odd;
        in_valid = 1'b1;
        in_data = w;
        ser_ready = 1'b1;
        #1 chk("idle_ready", 32'(rdy_e), 1);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            logic eb;
            eb = (i < 8) ? w[i] : exp_par;
            chk_bit("bit", eb, i == 0, i == 8);
            if (stall) begin
                ser_ready = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    chk_bit("stall", eb, i == 0, i == 8);
                end
                ser_ready = 1'b1;
            end
            @(negedge clk);
        end
        chk("end_busy", 32'(sb), 0);
        chk("par_bit", 32'(sp), 32'(exp_par));
        chk("frame_cnt", 32'(sc), 32'(exp_cnt));
    endtask

    initial begin
        logic [7:0] w;
        logic       eb;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'({val_e, val_o}), 0);
        chk("rst_out", 32'({out_e, out_o}), 0);
        chk("rst_flags", 32'({fst_e, lst_e, fst_o, lst_o}), 0);
        chk("rst_busy", 32'({bsy_e, bsy_o}), 0);
        chk("rst_ready", 32'({rdy_e, rdy_o}), 0);
        chk("rst_cnt", 32'(cnt_e), 0);
        rst = 1'b1;
        #1 chk("rel_ready", 32'(rdy_e), 1);
        chk("rel_cnt", 32'(cnt_e), 0);
        @(negedge clk);

        run_frame(8'hA5, 1'b0, 1'b0, 1'b0, 8'd1);
        run_frame(8'h07, 1'b1, 1'b0, 1'b0, 8'd2);
        run_frame(8'h03, 1'b1, 1'b0, 1'b1, 8'd3);
        run_frame(8'hFF, 1'b0, 1'b1, 1'b0, 8'd4);

        // Back-to-back: 0x01 then 0x02, 18 valid bits with no idle cycle
        sel = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h01;
        ser_ready = 1'b1;
        @(negedge clk);
        in_data = 8'h02;
        for (int i = 0; i < 18; i++) begin
            w = (i < 9) ? 8'h01 : 8'h02;
            eb = (i == 8 || i == 17) ? 1'b1 : w[i % 9];
            chk_bit("b2b", eb, i == 0 || i == 9, i == 8 || i == 17);
            if (i == 2) chk("b2b_busy_ready", 32'(rdy_e), 0);
            if (i == 8) chk("b2b_par_ready", 32'(rdy_e), 1);
            if (i == 9) in_valid = 1'b0;
            @(negedge clk);
        end
        chk("b2b_busy", 32'(bsy_e), 0);
        chk("b2b_par", 32'(par_e), 1);
        chk("b2b_cnt", 32'(cnt_e), 6);

        // Abort mid-frame with an asynchronous reset
        in_valid = 1'b1;
        in_data = 8'h5A;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_abort_out", 32'(out_e), 1);
        rst = 1'b0;
        #1 chk("abort_valid", 32'({val_e, val_o}), 0);
        chk("abort_out", 32'(out_e), 0);
        chk("abort_busy", 32'(bsy_e), 0);
        chk("abort_ready", 32'(rdy_e), 0);
        chk("abort_cnt", 32'(cnt_e), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_frame(8'h5A, 1'b0, 1'b0, 1'b0, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
